// File: rtl/multi_evt_counter.sv
// multi_evt_counter: NUM_CH independent WIDTH-bit event counters.
// Each channel counts single-cycle events. A per-channel clear resets the
// count, overflow flag and match pulse. Counters either wrap or saturate at
// their maximum. A global snapshot captures all counts atomically, and one
// channel at a time is read out through a registered mux.
//
// Ports:
//   clk_in         system clock, all logic on posedge
//   rst_in         synchronous reset, active low
//   en_in          global count enable
//   evt_in         per-channel event strobe
//   clr_in         per-channel clear (count, overflow, match)
//   snap_in        capture all pre-update counts into snapshot registers
//   sel_in         readout channel select (>= NUM_CH reads 0)
//   thresh_in      shared match threshold
//   rd_count_out   registered live count of the selected channel
//   rd_snap_out    registered snapshot of the selected channel
//   ovf_out        sticky overflow flag per channel
//   match_out      one-cycle pulse per channel when an increment hits thresh_in
//   snap_valid_out high once any snapshot has been taken
module multi_evt_counter #(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned WIDTH    = 16,
  parameter bit          SATURATE = 1'b0,
  parameter int unsigned SEL_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              en_in,
  input  logic [NUM_CH-1:0] evt_in,
  input  logic [NUM_CH-1:0] clr_in,
  input  logic              snap_in,
  input  logic [SEL_W-1:0]  sel_in,
  input  logic [WIDTH-1:0]  thresh_in,
  output logic [WIDTH-1:0]  rd_count_out,
  output logic [WIDTH-1:0]  rd_snap_out,
  output logic [NUM_CH-1:0] ovf_out,
  output logic [NUM_CH-1:0] match_out,
  output logic              snap_valid_out
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0]  count_q [NUM_CH];
  logic [WIDTH-1:0]  snap_q  [NUM_CH];
  logic [WIDTH-1:0]  count_d [NUM_CH];
  logic [NUM_CH-1:0] ovf_d;
  logic [NUM_CH-1:0] match_d;
  logic [WIDTH-1:0]  rd_count_d;
  logic [WIDTH-1:0]  rd_snap_d;

  // Per-channel next state: clear beats increment.
  always_comb begin
    for (int c = 0; c < int'(NUM_CH); c++) begin
      count_d[c] = count_q[c];
      ovf_d[c]   = ovf_out[c];
      match_d[c] = 1'b0;
      if (clr_in[c]) begin
        count_d[c] = '0;
        ovf_d[c]   = 1'b0;
      end else if (en_in && evt_in[c]) begin
        if (count_q[c] == CNT_MAX) begin
          ovf_d[c] = 1'b1;
          // A saturated hold is not a new arrival at the threshold.
          if (!SATURATE) begin
            count_d[c] = '0;
            match_d[c] = (thresh_in == '0);
          end
        end else begin
          count_d[c] = count_q[c] + WIDTH'(1);
          match_d[c] = (count_d[c] == thresh_in);
        end
      end
    end
  end

  // Readout mux; out-of-range selects match no channel and read 0.
  always_comb begin
    rd_count_d = '0;
    rd_snap_d  = '0;
    for (int c = 0; c < int'(NUM_CH); c++) begin
      if (sel_in == SEL_W'(c)) begin
        rd_count_d = count_q[c];
        rd_snap_d  = snap_q[c];
      end
    end
  end

  // State registers; snapshot takes the pre-update counts.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      for (int c = 0; c < int'(NUM_CH); c++) begin
        count_q[c] <= '0;
        snap_q[c]  <= '0;
      end
      ovf_out        <= '0;
      match_out      <= '0;
      snap_valid_out <= 1'b0;
      rd_count_out   <= '0;
      rd_snap_out    <= '0;
    end else begin
      for (int c = 0; c < int'(NUM_CH); c++) begin
        count_q[c] <= count_d[c];
        if (snap_in) begin
          snap_q[c] <= count_q[c];
        end
      end
      ovf_out   <= ovf_d;
      match_out <= match_d;
      if (snap_in) begin
        snap_valid_out <= 1'b1;
      end
      rd_count_out <= rd_count_d;
      rd_snap_out  <= rd_snap_d;
    end
  end

endmodule
